// File: rtl/spram_rr_arbiter_if.sv
// Bundle of requester command, read-response and RAM port signals for spram_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface spram_rr_arbiter_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 60
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_wren;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_wren;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_data;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DWIDTH-1:0] rsp_data;
  logic [AWIDTH-1:0] ram_address;
  logic              ram_wren;
  logic [DWIDTH-1:0] ram_data;
  logic [DWIDTH-1:0] ram_out;

  modport slave (
    input  req0_valid, req0_wren, req0_addr, req0_data,
    input  req1_valid, req1_wren, req1_addr, req1_data,
    input  ram_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    output ram_address, ram_wren, ram_data
  );

  modport master (
    output req0_valid, req0_wren, req0_addr, req0_data,
    output req1_valid, req1_wren, req1_addr, req1_data,
    output ram_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    input  ram_address, ram_wren, ram_data
  );
endinterface

// File: rtl/spram_rr_arbiter.sv
// Two-requester arbiter owning a single-port RAM; registered RAM port, 2-cycle read response.
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module spram_rr_arbiter #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 60,
  parameter int NUM_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  spram_rr_arbiter_if.slave     bus
);

  if (NUM_WORDS > (1 << AWIDTH)) begin : g_depth_bad
    $error("NUM_WORDS exceeds the AWIDTH address space");
  end

  logic              grant_vld;
  logic              grant_id;
  logic              sel_wren;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;

  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DWIDTH-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              rsp_vld_p0_q, rsp_vld_p0_d;
  logic              rsp_id_p0_q, rsp_id_p0_d;
  logic              rsp_vld_p1_q, rsp_vld_p1_d;
  logic              rsp_id_p1_q, rsp_id_p1_d;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
  logic tie_winner;
  assign tie_winner = 1'b0;
`else
  logic last_grant_q, last_grant_d;
  logic tie_winner;
  assign tie_winner = ~last_grant_q;
`endif

  // Arbitration: no grant while reset is held, so both readies stay low.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (!reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = tie_winner;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_vld && !grant_id;
  assign bus.req1_ready = grant_vld &&  grant_id;

  assign sel_wren = grant_id ? bus.req1_wren : bus.req0_wren;
  assign sel_addr = grant_id ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant_id ? bus.req1_data : bus.req0_data;

  // Without a grant the RAM port keeps its address and does a harmless read.
  always_comb begin
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    if (grant_vld) begin
      ram_addr_d = sel_addr;
      ram_data_d = sel_data;
      ram_wren_d = sel_wren;
    end
    rsp_vld_p0_d = grant_vld && !sel_wren;
    rsp_id_p0_d  = grant_id;
    rsp_vld_p1_d = rsp_vld_p0_q;
    rsp_id_p1_d  = rsp_id_p0_q;
  end

`ifndef SPRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      last_grant_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // p0: command registered onto the RAM port; p1: RAM output register holds the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
      rsp_vld_p0_q <= 1'b0;
      rsp_id_p0_q  <= 1'b0;
      rsp_vld_p1_q <= 1'b0;
      rsp_id_p1_q  <= 1'b0;
    end else begin
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      rsp_vld_p0_q <= rsp_vld_p0_d;
      rsp_id_p0_q  <= rsp_id_p0_d;
      rsp_vld_p1_q <= rsp_vld_p1_d;
      rsp_id_p1_q  <= rsp_id_p1_d;
    end
  end

  assign bus.ram_address = ram_addr_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.rsp0_valid  = rsp_vld_p1_q && !rsp_id_p1_q;
  assign bus.rsp1_valid  = rsp_vld_p1_q &&  rsp_id_p1_q;
  assign bus.rsp_data    = bus.ram_out;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Scoreboard bench for spram_rr_arbiter: queued requester agents, behavioural RAM, and a
// negedge monitor checking ready, RAM port and read responses against a reference model.
module tb_spram_rr_arbiter;
  localparam int AW = 12;
  localparam int DW = 60;

  typedef struct {
    logic          v;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spram_rr_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  spram_rr_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(4096)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural RAM with a registered read output.
  logic [DW-1:0] ram_m [4096];
  logic [DW-1:0] ram_out_q;
  always @(posedge clk) begin
    if (bus.ram_wren) ram_m[bus.ram_address] <= bus.ram_data;
    ram_out_q <= ram_m[bus.ram_address];
  end
  assign bus.ram_out = ram_out_q;

  // Reference model state
  logic [DW-1:0] mdl_mem [4096];
  exp_t          sb[$];
  logic          last_m = 1'b1;
  logic          prev_rst = 1'b1;
  logic          pg_v = 1'b0, pg_w = 1'b0;
  logic [AW-1:0] ea = '0;
  logic [DW-1:0] ed = '0;
  logic          armed = 1'b0;
  int            cyc = 0;
  int            n_chk = 0, n_pass = 0;

  cmd_t q0[$], q1[$];
  logic busy0 = 1'b0, busy1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0;

  function automatic logic [DW-1:0] pat(input int i);
    logic [11:0] a;
    a = i[11:0];
    return {a, ~a, 12'h5A5, a ^ 12'hC3C, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor + reference model, evaluated mid-cycle when all inputs are stable.
  always @(negedge clk) begin
    logic e0, e1, r0, r1, gw;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd, rd;
    exp_t e;
    cyc++;
    acc0 = bus.req0_valid && bus.req0_ready;
    acc1 = bus.req1_valid && bus.req1_ready;
    if (armed) begin
      if (prev_rst) begin ea = '0; ed = '0; pg_w = 1'b0; end
      else if (!pg_v) pg_w = 1'b0;
      chk("ram_wren", 64'(bus.ram_wren), 64'(pg_w));
      chk("ram_address", 64'(bus.ram_address), 64'(ea));
      chk("ram_data", 64'(bus.ram_data), 64'(ed));

      r0 = 1'b0; r1 = 1'b0; rd = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        r0 = !e.id; r1 = e.id; rd = e.data;
      end
      chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(r0));
      chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(r1));
      if (r0 || r1) chk("rsp_data", 64'(bus.rsp_data), 64'(rd));

`ifdef SPRAM_ARB_FIXED_PRIO_EN
      e0 = !reset && bus.req0_valid;
`else
      e0 = !reset && bus.req0_valid && (!bus.req1_valid || last_m);
`endif
      e1 = !reset && bus.req1_valid && !e0;
      chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
      chk("req1_ready", 64'(bus.req1_ready), 64'(e1));

      pg_v = e0 || e1;
      if (reset) begin
        sb.delete();
        last_m = 1'b1;
      end else if (pg_v) begin
        gw = e1 ? bus.req1_wren : bus.req0_wren;
        ga = e1 ? bus.req1_addr : bus.req0_addr;
        gd = e1 ? bus.req1_data : bus.req0_data;
        last_m = e1;
        pg_w = gw; ea = ga; ed = gd;
        if (gw) mdl_mem[ga] = gd;
        else sb.push_back('{due: cyc + 2, id: e1, data: mdl_mem[ga]});
      end
    end
    prev_rst = reset;
  end

  // Requester agents: hold each command until accepted, then take the next one.
  always begin
    cmd_t c;
    @(posedge clk);
    #1;
    if (!busy0 || acc0) begin
      busy0 = 1'b0;
      bus.req0_valid = 1'b0;
      if (q0.size() > 0) begin
        c = q0.pop_front();
        bus.req0_valid = c.v; bus.req0_wren = c.wren;
        bus.req0_addr = c.addr; bus.req0_data = c.data;
        busy0 = c.v;
      end
    end
    if (!busy1 || acc1) begin
      busy1 = 1'b0;
      bus.req1_valid = 1'b0;
      if (q1.size() > 0) begin
        c = q1.pop_front();
        bus.req1_valid = c.v; bus.req1_wren = c.wren;
        bus.req1_addr = c.addr; bus.req1_data = c.data;
        busy1 = c.v;
      end
    end
  end

  task automatic push(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c = '{v: 1'b1, wren: w, addr: a, data: d};
    if (n == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy0 || busy1 || sb.size() > 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 2000), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1 reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    logic [63:0] r;
    int n;
    for (int i = 0; i < 4096; i++) begin ram_m[i] = pat(i); mdl_mem[i] = pat(i); end
    bus.req0_valid = 1'b0; bus.req0_wren = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_wren = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 armed = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_ram_wren", 64'(bus.ram_wren), 64'd0);
    chk("idle_ram_address", 64'(bus.ram_address), 64'd0);

    // Write then read back the same address.
    push(0, 1'b1, 12'h005, 60'h0123456789ABCDE);
    push(0, 1'b0, 12'h005, '0);
    drain();

    // Continuous contention from a fresh reset: 0 wins first, then alternate.
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b0, 12'h010, '0);
      push(1, 1'b0, 12'h020, '0);
    end
    drain();

    // A lone req0 grant sets up the tie so req1's write goes first.
    push(0, 1'b0, 12'h100, '0);
    drain();
    push(1, 1'b1, 12'hFFF, 60'hFFFFFFFFFFFFFFF);
    push(0, 1'b0, 12'hFFF, '0);
    drain();

    // Reset one cycle after a read is accepted: the response must vanish.
    push(0, 1'b0, 12'h010, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.req0_valid && bus.req0_ready) && n < 50);
    chk("accept_before_reset", 64'(n < 50), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drain();

    // Randomized mixed traffic on a small address set to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 2; k++) begin
        r = {$urandom(), $urandom()};
        c.v    = ($urandom_range(0, 3) != 0);
        c.wren = r[0];
        c.addr = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
        c.data = r[63:4];
        if (k == 0) q0.push_back(c); else q1.push_back(c);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
